// File: rtl/ram_mp.sv
// Multi-port RAM with byte-masked writes, optional registered reads with
// write-first bypass, and a clear sequencer that fills the whole array.
module ram_mp #(
    parameter int                    ADDR_WIDTH  = 6,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    READ_PORTS  = 2,
    parameter int                    SYNC_READ   = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_req,
    output logic                             busy,
    input  logic                             write_en,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH/8-1:0]          write_mask,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             write_err,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data
);

    localparam int                    RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int                    LANES     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    write_err_q, write_err_d;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   merged_word;

    assign busy      = (state_q == ST_CLEAR);
    assign write_err = write_err_q;

    // Old word with the enabled lanes replaced; also the bypass value.
    always_comb begin
        merged_word = mem[write_addr];
        for (int i = 0; i < LANES; i++) begin
            if (write_mask[i]) merged_word[8*i +: 8] = in_data[8*i +: 8];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        write_err_d = write_en && busy;
        mem_we      = 1'b0;
        mem_waddr   = write_addr;
        mem_wdata   = merged_word;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = CLEAR_VALUE;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                mem_we = write_en;
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            write_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            write_err_q <= write_err_d;
        end
    end

    // NOTE: the array has no reset; the clear sequencer initialises it instead.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    if (SYNC_READ != 0) begin : g_sync_read
        logic [DATA_WIDTH-1:0] rd_data_q [READ_PORTS];
        logic [DATA_WIDTH-1:0] rd_data_d [READ_PORTS];

        always_comb begin
            for (int p = 0; p < READ_PORTS; p++) begin
                if (mem_we && (mem_waddr == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]))
                    rd_data_d[p] = mem_wdata;
                else
                    rd_data_d[p] = mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end

        always_ff @(posedge clk) begin
            for (int p = 0; p < READ_PORTS; p++) begin
                if (rst) rd_data_q[p] <= '0;
                else     rd_data_q[p] <= rd_data_d[p];
            end
        end

        always_comb begin
            for (int p = 0; p < READ_PORTS; p++) begin
                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = busy ? '0 : rd_data_q[p];
            end
        end
    end else begin : g_async_read
        always_comb begin
            for (int p = 0; p < READ_PORTS; p++) begin
                rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
                    busy ? '0 : mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

endmodule

// File: tb/tb_ram_mp.sv
// Bench for ram_mp: an asynchronous-read and a registered-read instance share
// stimulus and are compared against an array-based model of the memory.
module tb_ram_mp;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int NP    = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_req;
    logic              write_en;
    logic [AW-1:0]     write_addr;
    logic [DW/8-1:0]   write_mask;
    logic [DW-1:0]     in_data;
    logic [NP*AW-1:0]  rd_addr;
    logic              busy_a, busy_s, werr_a, werr_s;
    logic [NP*DW-1:0]  rd_data_a, rd_data_s;

    int total = 0;
    int bad   = 0;

    ram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(NP), .SYNC_READ(0)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
        .write_en(write_en), .write_addr(write_addr), .write_mask(write_mask),
        .in_data(in_data), .write_err(werr_a), .rd_addr(rd_addr), .rd_data(rd_data_a)
    );

    ram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(NP), .SYNC_READ(1)) dut_s (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_s),
        .write_en(write_en), .write_addr(write_addr), .write_mask(write_mask),
        .in_data(in_data), .write_err(werr_s), .rd_addr(rd_addr), .rd_data(rd_data_s)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the array contents, whether a clear is running and
    // which address it fills next, the pending error pulse and registered reads.
    logic [DW-1:0] mem_m [DEPTH];
    bit            clearing_m = 1'b1;
    int            ptr_m      = 0;
    bit            err_m      = 1'b0;
    logic [DW-1:0] sync_m [NP] = '{default: '0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] port_addr(input int p);
        return rd_addr[p*AW +: AW];
    endfunction

    task automatic model_edge();
        if (rst) begin
            clearing_m = 1'b1;
            ptr_m      = 0;
            err_m      = 1'b0;
            for (int p = 0; p < NP; p++) sync_m[p] = '0;
        end else begin
            err_m = write_en && clearing_m;
            if (clearing_m) begin
                mem_m[ptr_m] = '0;
                if (ptr_m == DEPTH - 1) clearing_m = 1'b0;
                else ptr_m++;
            end else begin
                if (write_en) begin
                    for (int i = 0; i < DW/8; i++)
                        if (write_mask[i]) mem_m[write_addr][8*i +: 8] = in_data[8*i +: 8];
                end
                if (clr_req) begin
                    clearing_m = 1'b1;
                    ptr_m      = 0;
                end
            end
            for (int p = 0; p < NP; p++) sync_m[p] = mem_m[port_addr(p)];
        end
    endtask

    task automatic compare_all();
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_s;
        check("busy_async", 32'(busy_a), 32'(clearing_m));
        check("busy_sync",  32'(busy_s), 32'(clearing_m));
        check("werr_async", 32'(werr_a), 32'(err_m));
        check("werr_sync",  32'(werr_s), 32'(err_m));
        for (int p = 0; p < NP; p++) begin
            exp_a = clearing_m ? '0 : mem_m[port_addr(p)];
            exp_s = clearing_m ? '0 : sync_m[p];
            check($sformatf("rd_async_p%0d", p), 32'(rd_data_a[p*DW +: DW]), 32'(exp_a));
            check($sformatf("rd_sync_p%0d", p),  32'(rd_data_s[p*DW +: DW]), 32'(exp_s));
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic count_busy(output int n, output int errs);
        n    = 0;
        errs = 0;
        while (busy_a === 1'b1 && n < 200) begin
            n++;
            step();
            if (werr_a === 1'b1) errs++;
        end
    endtask

    task automatic read_all_zero(input string tag);
        int z = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = {AW'(DEPTH - 1 - a), AW'(a)};
            #1;
            if (rd_data_a[DW-1:0] !== '0 || rd_data_a[2*DW-1:DW] !== '0) z++;
            step();
        end
        check(tag, 32'(z), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
        write_en   = 1'b1;
        write_addr = a;
        in_data    = d;
        write_mask = m;
        step();
        write_en   = 1'b0;
    endtask

    int n, errs;

    initial begin
        rst        = 1'b1;
        clr_req    = 1'b0;
        write_en   = 1'b0;
        write_addr = '0;
        write_mask = '0;
        in_data    = '0;
        rd_addr    = '0;

        @(posedge clk);
        model_edge();
        #1;
        repeat (2) step();
        check("reset_busy", 32'(busy_a), 32'd1);
        check("reset_werr", 32'(werr_s), 32'd0);

        // Power-up clear length, then the whole array reads zero.
        rst = 1'b0;
        count_busy(n, errs);
        check("init_clear_cycles", 32'(n), 32'd64);
        read_all_zero("init_all_zero");

        // Byte-masked merge.
        do_write(6'd5, 16'hBEEF, 2'b11);
        do_write(6'd5, 16'h1234, 2'b01);
        rd_addr = {6'd0, 6'd5};
        #1;
        check("mask_merge_async", 32'(rd_data_a[DW-1:0]), 32'h0000BE34);
        step();
        check("mask_merge_sync", 32'(rd_data_s[DW-1:0]), 32'h0000BE34);

        // Zero mask is a silent no-op.
        do_write(6'd5, 16'hFFFF, 2'b00);
        check("zero_mask_data", 32'(rd_data_a[DW-1:0]), 32'h0000BE34);
        check("zero_mask_err", 32'(werr_a), 32'd0);

        // Same-cycle write and registered read of the same address.
        rd_addr = {6'd9, 6'd8};
        do_write(6'd9, 16'hA5A5, 2'b11);
        check("sync_bypass_p1", 32'(rd_data_s[2*DW-1:DW]), 32'h0000A5A5);
        check("sync_other_p0",  32'(rd_data_s[DW-1:0]),    32'h00000000);

        // Clear request together with a write.
        clr_req = 1'b1;
        do_write(6'd3, 16'hCAFE, 2'b11);
        clr_req = 1'b0;
        count_busy(n, errs);
        check("clr_write_cycles", 32'(n), 32'd64);
        check("clr_write_no_err", 32'(errs), 32'd0);
        rd_addr = {6'd5, 6'd3};
        #1;
        check("clr_write_addr3", 32'(rd_data_a[DW-1:0]), 32'h0);
        check("clr_write_addr5", 32'(rd_data_a[2*DW-1:DW]), 32'h0);

        // Writes while busy are dropped and flagged one cycle late.
        do_write(6'd7, 16'h1111, 2'b11);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        errs = 0;
        write_en   = 1'b1;
        write_mask = 2'b11;
        for (int k = 0; k < 3; k++) begin
            write_addr = AW'(10 + k);
            in_data    = 16'h7777;
            step();
            if (werr_a === 1'b1) errs++;
        end
        write_en = 1'b0;
        step();
        if (werr_a === 1'b1) errs++;
        check("busy_drop_pulses", 32'(errs), 32'd3);
        count_busy(n, errs);
        read_all_zero("busy_drop_all_zero");

        // Reset part-way through a clear restarts it.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(n, errs);
        check("reset_mid_clear_cycles", 32'(n), 32'd64);

        // Random traffic with collisions, rare clears and resets.
        for (int c = 0; c < 1500; c++) begin
            rst        = ($urandom_range(0, 399) == 0);
            clr_req    = ($urandom_range(0, 149) == 0);
            write_en   = ($urandom_range(0, 2) != 0);
            write_addr = AW'($urandom_range(0, 15));
            write_mask = 2'($urandom_range(0, 3));
            in_data    = DW'($urandom);
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 2) == 0) rd_addr[p*AW +: AW] = write_addr;
                else rd_addr[p*AW +: AW] = AW'($urandom_range(0, 15));
            end
            step();
        end
        rst      = 1'b0;
        clr_req  = 1'b0;
        write_en = 1'b0;
        repeat (70) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_mp.md
# ram_mp

Parametrised multi-port RAM that succeeds the 2-read/1-write 64x16 program/data memory. It provides a configurable number of read ports, byte-masked writes, selectable asynchronous or registered reads with write-first bypass, and a hardware clear sequencer. The sequencer zero-fills (or value-fills) the whole array after reset or on request. It sits between the CPU datapath (instruction fetch and operand ports) and the write-back stage.

## Interface
- ADDR_WIDTH, 6, address bits; RAM_DEPTH = 1 << ADDR_WIDTH
- DATA_WIDTH, 16, word width; must be a multiple of 8
- READ_PORTS, 2, number of independent read ports (1..4)
- SYNC_READ, 0, 0 = combinational read, 1 = registered read with write-first bypass
- CLEAR_VALUE, 0, word written to every location by the clear sequencer
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- clr_req  in  1  request a full-array clear; sampled only when not busy
- busy  out  1  high while the clear sequencer runs
- write_en  in  1  write strobe
- write_addr  in  ADDR_WIDTH  write address
- write_mask  in  DATA_WIDTH/8  byte-lane enables; bit i covers bits [8i+7:8i]
- in_data  in  DATA_WIDTH  write data
- write_err  out  1  one-cycle pulse: a write was dropped because busy was high
- rd_addr  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  READ_PORTS*DATA_WIDTH  packed read data; port p at [p*DATA_WIDTH +: DATA_WIDTH]

## Operation
- The state machine has two states, CLEAR and IDLE. rst forces CLEAR with clr_ptr = 0.
- In CLEAR, each cycle writes CLEAR_VALUE to mem[clr_ptr] and increments clr_ptr. The cycle that writes RAM_DEPTH-1 transitions to IDLE.
- In IDLE, clr_req=1 moves to CLEAR with clr_ptr = 0 on the next edge. clr_req while busy is ignored and not queued.
- busy = 1 exactly while in CLEAR (combinational decode of state).
- Writes are accepted only in IDLE. For each lane with write_mask[i] = 1, mem[write_addr] lane i takes in_data lane i. Other lanes are unchanged.
- write_mask = 0 with write_en = 1 is a legal no-op and does not raise write_err.
- write_en = 1 while busy drops the write. write_err pulses high on the following cycle.
- clr_req and write_en together in IDLE: the write completes on that edge, then CLEAR starts and eventually overwrites it.
- Reads are independent per port. Any number of ports may use the same address.
- While busy, every rd_data port outputs 0, in both SYNC_READ modes.
- SYNC_READ=0: rd_data[p] = mem[rd_addr[p]] combinationally. A write becomes visible immediately after the edge that performs it.
- SYNC_READ=1: rd_data[p] is registered from rd_addr[p]. If a write to the same address occurs in the same cycle, the register takes the merged word: new lanes where the mask is set, old lanes elsewhere.
- Reset mid-clear restarts the clear from address 0. Reset mid-write discards that write.

## Timing
- Reset values: busy = 1 (state CLEAR), write_err = 0, clr_ptr = 0, registered rd_data = 0.
- A full clear takes RAM_DEPTH cycles. With rst deasserted at edge 0, busy falls after edge RAM_DEPTH: cycle 64 at the defaults.
- Write latency is one edge. Read latency is 0 cycles (SYNC_READ=0) or 1 cycle (SYNC_READ=1).
- write_err rises one cycle after the dropped write_en and lasts one cycle per dropped write. Back-to-back drops produce back-to-back pulses.
- clr_ptr wraps by terminal compare, not by overflow. No address beyond RAM_DEPTH-1 is ever written.

## Test plan
- Release rst, count cycles -> busy high for exactly 64 cycles. Every address then reads 0x0000 on both ports.
- In IDLE, write 0xBEEF to addr 5 with mask 2'b11, then mask 2'b01 with data 0x1234 -> addr 5 reads 0xBE34.
- SYNC_READ=1, write 0xA5A5 to addr 9 while port 1 reads addr 9 in the same cycle -> port 1 shows 0xA5A5 the next cycle. Port 0 reading addr 8 is unaffected.
- Pulse clr_req with write_en to addr 3 in the same cycle -> busy for 64 cycles, addr 3 reads 0 afterward, no write_err.
- During clear, drive write_en for 3 consecutive cycles -> write_err high for 3 cycles, each one cycle late. The array stays all-zero.
- Assert rst at clear cycle 30 -> the clear restarts and busy lasts 64 more cycles from the reset release.
